// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the frame FSM state encoding, the program-memory geometry, the
// default frame sync marker and a small LEN-range helper.
package prog_loader_pkg;

  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int INSTR_W   = 8;
  // LEN counts up to MEM_DEPTH inclusive, so it needs one bit more than ADDR_W.
  localparam int LEN_W     = 5;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    RUN
  } state_t;

  // A frame length byte is usable only if it names 1..MEM_DEPTH words.
  function automatic logic len_valid(input logic [7:0] b);
    return (b != 8'h00) && (b <= 8'(MEM_DEPTH));
  endfunction

endpackage

// File: rtl/prog_mem16x8.sv
// 16x8 instruction store.
// Ports:
//   clk    - write clock, rising edge
//   reset  - asynchronous active-low clear of every word to 8'h00 (a no-op)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (from the core's program counter)
//   rdata  - combinational read data, mem[raddr]
module prog_mem16x8
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];

  // NOTE: this array is built from flops so every word can be cleared to a
  // known no-op on reset; a RAM macro could not be reset this way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The core fetches without a clock delay.
  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader and instruction store for the 4-bit core.
// Receives a framed byte stream (SYNC, LEN, LEN data bytes, CSUM), fills the
// program memory and releases the core from reset once a frame checks out.
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   in_valid   - in_data holds a byte
//   in_data    - stream byte
//   in_ready   - loader accepts a byte this cycle (always 1)
//   adr        - instruction address from the core
//   dout       - instruction at mem[adr], combinational
//   cpu_reset  - registered active-low reset to the core
//   busy       - a frame is in progress (LEN, DATA or CSUM)
//   err        - last frame rejected; sticky until the next accepted sync
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  adr,
  output logic [INSTR_W-1:0] dout,
  output logic               cpu_reset,
  output logic               busy,
  output logic               err
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wr_ptr;
  logic [7:0]       sum;

  logic             accept;
  logic             mem_we;
  logic [LEN_W-1:0] wr_ptr_nxt;

  assign in_ready   = 1'b1;
  assign accept     = in_valid && in_ready;
  assign mem_we     = accept && (state == DATA);
  assign wr_ptr_nxt = wr_ptr + 1'b1;

  prog_mem16x8 u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (adr),
    .rdata (dout)
  );

  // NOTE: all state here is sequential, so it is assigned with <= only;
  // blocking assignments would let later statements see half-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      cpu_reset <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      case (state)
        // Sync from RUN is a live reload: the core goes back into reset.
        IDLE, RUN: begin
          if (in_data == SYNC_BYTE) begin
            state     <= LEN;
            err       <= 1'b0;
            cpu_reset <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LEN: begin
          if (len_valid(in_data)) begin
            len_q  <= in_data[LEN_W-1:0];
            sum    <= in_data;
            wr_ptr <= '0;
            state  <= DATA;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        // SYNC_BYTE is ordinary payload here; only the count ends the data.
        DATA: begin
          sum    <= sum + in_data;
          wr_ptr <= wr_ptr_nxt;
          if (wr_ptr_nxt == len_q) state <= CSUM;
        end
        CSUM: begin
          busy <= 1'b0;
          if (in_data == sum) begin
            state     <= RUN;
            cpu_reset <= 1'b1;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader and instruction store for the 4-bit core. It owns the 16×8 program memory that feeds the core's `dout` from the core's `adr`, and fills that memory from a framed byte stream. The core is held in reset until a frame has been received with a correct checksum. It sits directly upstream of the core: its `dout` drives the core's instruction input and its `cpu_reset` drives the core's active-low `reset`.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `in_valid` input 1: `in_data` holds a byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte this cycle.
- `adr` input 4: instruction address from the core's program counter.
- `dout` output 8: instruction at `mem[adr]`, combinational read.
- `cpu_reset` output 1: active-low reset to the core, registered.
- `busy` output 1: a frame is in progress (any state other than IDLE or RUN).
- `err` output 1: the last frame was rejected; sticky until the next sync byte is accepted.

## Operation
- **Byte acceptance:** a byte is accepted on a rising edge with `in_valid && in_ready`. `in_ready` is 1 in every state, so at most one byte is accepted per cycle. Idle gaps (`in_valid`=0) are allowed anywhere in a frame.
- **Frame format:** `SYNC_BYTE`, then LEN, then LEN data bytes, then CSUM.
  - LEN must be 1..16.
  - CSUM = (LEN + sum of data bytes) mod 256.
- **States:**
  - IDLE: non-sync bytes are discarded. Sync goes to LEN, clears `err`, and drives `cpu_reset`=0.
  - LEN: a LEN of 0 or >16 sets `err` and goes to IDLE. Otherwise store LEN, set sum=LEN, set wr_ptr=0, and go to DATA.
  - DATA: write `mem[wr_ptr]`=byte, sum+=byte, wr_ptr++. After LEN bytes, go to CSUM. A byte equal to `SYNC_BYTE` is ordinary data here.
  - CSUM: on a match go to RUN and drive `cpu_reset`=1. On a mismatch set `err`, go to IDLE, and keep `cpu_reset`=0.
  - RUN: non-sync bytes are discarded. Sync behaves exactly as sync in IDLE, which allows a live reload.
- **Memory contents:** slots LEN..15 keep their previous contents. A rejected frame leaves partially written slots in place; this is harmless because the core stays in reset.
- **Arithmetic widths:** sum is 8 bits and wraps. wr_ptr is 5 bits, compared against LEN.

## Timing
- **Reset (async assert):**
  - state=IDLE
  - all 16 memory words = 8'h00 (MOV r0,r0, a no-op)
  - `cpu_reset`=0, `err`=0, `busy`=0
  - `dout`=8'h00
- **Memory write latency:** a data byte accepted at edge k is readable on `dout` after edge k.
- **Core release:** CSUM is accepted at edge k. `cpu_reset` rises immediately after edge k, so the core's first fetch is at edge k+1 with `adr`=0.
- **Reload:** sync accepted in RUN at edge k drops `cpu_reset` immediately after edge k.
- **Read path:** `dout` is a pure combinational function of `adr` and memory. No clock is involved in the read.
- **Reset mid-frame:** the frame is abandoned and all outputs take their reset values immediately.

## Structure
- A shared package `prog_loader_pkg` holds:
  - the state enum (IDLE, LEN, DATA, CSUM, RUN)
  - `MEM_DEPTH`=16
  - `ADDR_W`=4
  - `INSTR_W`=8
  - the default sync value 8'hA5
- Natural sub-module: `prog_mem16x8`, a 16×8 array with async clear, one synchronous write port and one combinational read port.
- The frame FSM, checksum and pointer logic live in the top level.

## Test plan
- **Good frame:** reset, then send A5 02 A3 90 35. Required: `cpu_reset`=1 after the CSUM edge, `mem[0]`=A3, `mem[1]`=90, `mem[2..15]`=00, `err`=0.
- **Bad checksum:** send A5 01 A3 00. Required: `err`=1, `cpu_reset` stays 0, `busy`=0, `mem[0]`=A3.
- **Bad length:** send A5 00, and separately A5 11. Required: `err`=1 right after the LEN byte, state IDLE. A following good frame clears `err` on its sync byte.
- **Valid gaps and sync as data:** send A5 03 A5 A5 A5 F2 with `in_valid` gaps of 0–3 cycles between bytes. Required: `mem[0..2]`=A5 and `cpu_reset`=1 (checksum 03+A5·3 = F2 mod 256).
- **Reset mid-frame:** assert `reset` after the second data byte of a 4-byte frame. Required: all memory reads 00, `cpu_reset`=0 immediately, and the next good frame loads normally.
- **Live reload:** while in RUN, send A5 01 98 99. Required: `cpu_reset` drops on the sync edge, `mem[0]`=98, `cpu_reset` returns to 1 after the CSUM edge, and `dout`=98 at `adr`=0.
